// File: rtl/mesh_pkg.sv
// Shared definitions for the systolic mesh datapath.
//   COLS  : number of mesh columns
//   ACC_W : width of one accumulator result
//   ID_W  : tile id width
//   mesh_row_t : one full row of column results plus its tile id and last flag.
//     It is used by the input feeder and by the output deskew FIFO.
package mesh_pkg;

  localparam int COLS  = 4;
  localparam int ACC_W = 20;
  localparam int ID_W  = 3;

  typedef struct packed {
    logic [COLS-1:0][ACC_W-1:0] c;
    logic [ID_W-1:0]            id;
    logic                       last;
  } mesh_row_t;

endpackage

// File: rtl/mesh_out_fifo.sv
// Synchronous FIFO of aligned mesh rows.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write request and row; accepted if not full, or if full with a pop in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head row, forced to zero while empty
//   count      : number of stored rows (log2(DEPTH)+1 bits)
//   full, empty: occupancy status
module mesh_out_fifo
  import mesh_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  mesh_row_t        din,
  input  logic             pop,
  output mesh_row_t        dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  mesh_row_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the incoming row may overwrite it.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mesh_out_deskew.sv
// Output deskew for the bottom row of the systolic mesh.
// Column j arrives j cycles after column 0; each column is delayed by
// (COLS-1-j) registers so a whole row lines up, then the aligned row is
// pushed into a FIFO drained over a valid/ready handshake.
// Optional build macro: MESH_OUT_ID_CHECK_EN -- carry id/last on every column
// and flag (id_err) any aligned row whose id/last disagree with column 0.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_c/in_id/in_last : skewed per-column inputs (column j at slice j)
//   out_valid/out_ready    : aligned-row handshake
//   out_c/out_id/out_last  : aligned row (id/last taken from column 0)
//   almost_full            : count >= DEPTH-COLS (room for rows still in the deskew chains)
//   overflow/skew_err/id_err : sticky error flags, cleared only by reset
module mesh_out_deskew
  import mesh_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLS-1:0]       in_valid,
  input  logic [COLS*ACC_W-1:0] in_c,
  input  logic [COLS*ID_W-1:0]  in_id,
  input  logic [COLS-1:0]       in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_c,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  skew_err,
  output logic                  id_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [COLS-1:0]  al_vld;
  logic [ACC_W-1:0] al_c [COLS];
  logic [ID_W-1:0]  al_id0;
  logic             al_last0;
`ifdef MESH_OUT_ID_CHECK_EN
  logic [COLS-1:0]  id_mis;
`endif

  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int L = COLS - 1 - j;

    // Stage boundary: per-column valid/data delay chain, L registers deep
    if (L == 0) begin : g_comb
      assign al_vld[j] = in_valid[j];
      assign al_c[j]   = in_c[j*ACC_W +: ACC_W];
    end else begin : g_dly
      logic [L-1:0]     vld_p;
      logic [ACC_W-1:0] c_p [L];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= '0;
          for (int k = 0; k < L; k++) c_p[k] <= '0;
        end else begin
          vld_p[0] <= in_valid[j];
          c_p[0]   <= in_c[j*ACC_W +: ACC_W];
          for (int k = 1; k < L; k++) begin
            vld_p[k] <= vld_p[k-1];
            c_p[k]   <= c_p[k-1];
          end
        end
      end

      assign al_vld[j] = vld_p[L-1];
      assign al_c[j]   = c_p[L-1];
    end

    // Stage boundary: id/last chains; column 0 always carries them because
    // the aligned row forwards column 0's id/last.
    if (j == 0) begin : g_id0
      logic [ID_W-1:0] id_p [L];
      logic [L-1:0]    last_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_p <= '0;
          for (int k = 0; k < L; k++) id_p[k] <= '0;
        end else begin
          id_p[0]   <= in_id[0 +: ID_W];
          last_p[0] <= in_last[0];
          for (int k = 1; k < L; k++) begin
            id_p[k]   <= id_p[k-1];
            last_p[k] <= last_p[k-1];
          end
        end
      end

      assign al_id0   = id_p[L-1];
      assign al_last0 = last_p[L-1];
`ifdef MESH_OUT_ID_CHECK_EN
      assign id_mis[0] = 1'b0;
`endif
    end else begin : g_idn
`ifdef MESH_OUT_ID_CHECK_EN
      logic [ID_W-1:0] ci;
      logic            cl;

      if (L == 0) begin : g_idc
        assign ci = in_id[j*ID_W +: ID_W];
        assign cl = in_last[j];
      end else begin : g_idd
        logic [ID_W-1:0] id_p [L];
        logic [L-1:0]    last_p;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            last_p <= '0;
            for (int k = 0; k < L; k++) id_p[k] <= '0;
          end else begin
            id_p[0]   <= in_id[j*ID_W +: ID_W];
            last_p[0] <= in_last[j];
            for (int k = 1; k < L; k++) begin
              id_p[k]   <= id_p[k-1];
              last_p[k] <= last_p[k-1];
            end
          end
        end

        assign ci = id_p[L-1];
        assign cl = last_p[L-1];
      end

      assign id_mis[j] = (ci != al_id0) || (cl != al_last0);
`else
      // Without the id check these columns' id/last are not needed.
      logic unused_idl;
      assign unused_idl = ^{in_id[j*ID_W +: ID_W], in_last[j]};
`endif
    end
  end

  // Stage boundary: aligned row -> FIFO
  logic             all_vld;
  logic             any_vld;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  mesh_row_t        push_row;
  mesh_row_t        head_row;

  assign all_vld = &al_vld;
  assign any_vld = |al_vld;

  always_comb begin
    push_row = '0;
    for (int j = 0; j < COLS; j++) push_row.c[j] = al_c[j];
    push_row.id   = al_id0;
    push_row.last = al_last0;
  end

  mesh_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (all_vld),
    .din   (push_row),
    .pop   (pop),
    .dout  (head_row),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;
  assign out_c       = head_row.c;
  assign out_id      = head_row.id;
  assign out_last    = head_row.last;
  assign almost_full = (fifo_count >= CNT_W'(DEPTH - COLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      // The mesh cannot stall, so a row arriving at a full FIFO with no pop is lost.
      if (all_vld && fifo_full && !pop) overflow <= 1'b1;
      if (any_vld && !all_vld)          skew_err <= 1'b1;
    end
  end

`ifdef MESH_OUT_ID_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_err <= 1'b0;
    else if (all_vld && (|id_mis)) id_err <= 1'b1;
  end
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_out_deskew.sv
module tb_mesh_out_deskew;
  import mesh_pkg::*;

  localparam int DEPTH = 8;
`ifdef MESH_OUT_ID_CHECK_EN
  localparam logic EXP_IDERR = 1'b1;
`else
  localparam logic EXP_IDERR = 1'b0;
`endif

  typedef struct packed {
    logic [COLS-1:0]            vm;
    logic [COLS-1:0][ACC_W-1:0] c;
    logic [COLS-1:0][ID_W-1:0]  id;
    logic [COLS-1:0]            last;
  } stim_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [COLS-1:0]       in_valid;
  logic [COLS*ACC_W-1:0] in_c;
  logic [COLS*ID_W-1:0]  in_id;
  logic [COLS-1:0]       in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [COLS*ACC_W-1:0] out_c;
  logic [ID_W-1:0]       out_id;
  logic                  out_last;
  logic                  almost_full;
  logic                  overflow;
  logic                  skew_err;
  logic                  id_err;

  int n_checks = 0;
  int n_fail   = 0;
  int run_len  = 0;
  int max_run  = 0;
  int vld_seen = 0;

  mesh_row_t exp_q [$];
  stim_t     hist [COLS];

  mesh_out_deskew #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_c        (in_c),
    .in_id       (in_id),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_c       (out_c),
    .out_id      (out_id),
    .out_last    (out_last),
    .almost_full (almost_full),
    .overflow    (overflow),
    .skew_err    (skew_err),
    .id_err      (id_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Output monitor: every accepted row is compared against the scoreboard.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      run_len++;
      vld_seen++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      mesh_row_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_row: got c=%h id=%0d last=%0b, required no row", out_c, out_id, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_c, out_id, out_last} !== {e.c, e.id, e.last}) begin
          n_fail++;
          $display("FAIL row_data: got c=%h id=%0d last=%0b, required c=%h id=%0d last=%0b",
                   out_c, out_id, out_last, e.c, e.id, e.last);
        end
      end
    end
  end

  task automatic step(input stim_t r);
    for (int k = COLS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = r;
    for (int j = 0; j < COLS; j++) begin
      in_valid[j]              = hist[j].vm[j];
      in_c[j*ACC_W +: ACC_W]   = hist[j].c[j];
      in_id[j*ID_W +: ID_W]    = hist[j].id[j];
      in_last[j]               = hist[j].last[j];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic launch(input stim_t r, input bit expect_push);
    if (expect_push) exp_q.push_back({r.c, r.id[0], r.last[0]});
    step(r);
  endtask

  function automatic stim_t mk(input logic [ID_W-1:0] id, input logic lst);
    stim_t s;
    s.vm = '1;
    for (int j = 0; j < COLS; j++) begin
      s.c[j]    = ACC_W'($urandom);
      s.id[j]   = id;
      s.last[j] = lst;
    end
    return s;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step('0);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d rows still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < COLS; k++) hist[k] = '0;
    in_valid = '0;
    in_c     = '0;
    in_id    = '0;
    in_last  = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++; if (out_c !== '0)         begin n_fail++; $display("FAIL reset_out_c: got %h, required 0", out_c); end
    n_checks++; if (out_id !== '0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_id_last: got %0d/%b, required 0/0", out_id, out_last); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b, required 0", almost_full); end
    n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    n_checks++; if (skew_err !== 1'b0)    begin n_fail++; $display("FAIL reset_skew_err: got %b, required 0", skew_err); end
    n_checks++; if (id_err !== 1'b0)      begin n_fail++; $display("FAIL reset_id_err: got %b, required 0", id_err); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_row();
    stim_t s;
    out_ready = 1'b1;
    s.vm = '1;
    for (int j = 0; j < COLS; j++) begin
      s.c[j]    = ACC_W'(j + 1);
      s.id[j]   = 3'd5;
      s.last[j] = 1'b1;
    end
    launch(s, 1'b1);
    idle(2);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b, required 0", out_valid); end
    idle(1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b, required 1", out_valid); end
    n_checks++; if (out_c !== {20'd4, 20'd3, 20'd2, 20'd1}) begin n_fail++; $display("FAIL single_out_c: got %h, required 00004000030000200001", out_c); end
    n_checks++; if (out_id !== 3'd5 || out_last !== 1'b1) begin n_fail++; $display("FAIL single_id_last: got %0d/%b, required 5/1", out_id, out_last); end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    idle(2);
    max_run  = 0;
    vld_seen = 0;
    for (int r = 0; r < 8; r++) launch(mk(ID_W'(r), r == 7), 1'b1);
    wait_drain("b2b");
    idle(2);
    n_checks++; if (max_run != 8)  begin n_fail++; $display("FAIL b2b_consecutive: got run %0d, required 8", max_run); end
    n_checks++; if (vld_seen != 8) begin n_fail++; $display("FAIL b2b_row_count: got %0d, required 8", vld_seen); end
    n_checks++; if ({overflow, skew_err, id_err} !== 3'b000) begin n_fail++; $display("FAIL b2b_flags: got %b, required 000", {overflow, skew_err, id_err}); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int r = 0; r < 10; r++) begin
      launch(mk(ID_W'(r), 1'b0), r < DEPTH);
      if (r == 5) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL ovf_af_count3: got %b, required 0", almost_full); end
      end
      if (r == 6) begin
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL ovf_af_count4: got %b, required 1", almost_full); end
      end
      if (r == 9) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, required 0", overflow); end
      end
    end
    idle(4);
    n_checks++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_full_valid: got %b, required 1", out_valid); end
    out_ready = 1'b1;
    wait_drain("ovf");
    idle(2);
    n_checks++; if (almost_full !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_after_drain: got af=%b valid=%b, required 0/0", almost_full, out_valid); end
  endtask

  task automatic test_skew();
    stim_t s;
    out_ready = 1'b1;
    vld_seen  = 0;
    s = mk(3'd3, 1'b0);
    s.vm = 4'b1011;
    launch(s, 1'b0);
    idle(5);
    n_checks++; if (skew_err !== 1'b1) begin n_fail++; $display("FAIL skew_flag: got %b, required 1", skew_err); end
    n_checks++; if (vld_seen != 0)     begin n_fail++; $display("FAIL skew_no_push: got %0d rows, required 0", vld_seen); end
    launch(mk(3'd4, 1'b1), 1'b1);
    wait_drain("skew");
    n_checks++; if (vld_seen != 1)     begin n_fail++; $display("FAIL skew_next_row: got %0d rows, required 1", vld_seen); end
  endtask

  task automatic test_id_check();
    stim_t s;
    out_ready = 1'b1;
    n_checks++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL idchk_pre: got %b, required 0", id_err); end
    s = mk(3'd5, 1'b1);
    s.id[3] = 3'd6;
    launch(s, 1'b1);
    wait_drain("idchk");
    n_checks++; if (id_err !== EXP_IDERR) begin n_fail++; $display("FAIL idchk_flag: got %b, required %b", id_err, EXP_IDERR); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) launch(mk(ID_W'(r + 1), 1'b0), 1'b1);
    idle(3);
    launch(mk(3'd7, 1'b1), 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_c !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got valid=%b c=%h, required 0/0", out_valid, out_c); end
    n_checks++; if ({overflow, skew_err, id_err, almost_full} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags: got %b, required 0000", {overflow, skew_err, id_err, almost_full}); end
    exp_q.delete();
    clear_inputs();
    idle(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    vld_seen  = 0;
    idle(10);
    n_checks++; if (vld_seen != 0)     begin n_fail++; $display("FAIL rstmid_stale: got %0d rows, required 0", vld_seen); end
    n_checks++; if (skew_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_skew: got %b, required 0", skew_err); end
    launch(mk(3'd2, 1'b1), 1'b1);
    wait_drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_overflow();
    test_skew();
    test_id_check();
    test_reset_mid();
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
